// File: rtl/datapath_pkg.sv
// Shared types, saturation limits and saturating arithmetic helpers
// for the four-lane signed vector datapath.
package datapath_pkg;

    localparam int DATA_W = 8;

    typedef logic signed [DATA_W-1:0] data_t;

    localparam data_t SAT_MAX = data_t'(127);
    localparam data_t SAT_MIN = data_t'(-128);

    // The top two bits of the 9-bit sum disagree only on overflow.
    function automatic data_t sat_add(input data_t x, input data_t y);
        logic signed [DATA_W:0] s;
        data_t r;
        s = (DATA_W+1)'(x) + (DATA_W+1)'(y);
        case (s[DATA_W:DATA_W-1])
            2'b01:   r = SAT_MAX;
            2'b10:   r = SAT_MIN;
            default: r = s[DATA_W-1:0];
        endcase
        return r;
    endfunction

    function automatic data_t sat_mul(input data_t x, input data_t y);
        logic signed [2*DATA_W-1:0] p;
        data_t r;
        p = (2*DATA_W)'(x) * (2*DATA_W)'(y);
        if (p > 16'sd127)
            r = SAT_MAX;
        else if (p < -16'sd128)
            r = SAT_MIN;
        else
            r = p[DATA_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/datapath_lane.sv
// One lane: operand, product, two accumulator and output registers.
// Every right-hand side reads pre-edge register values.
module datapath_lane
    import datapath_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en_a,
    input  logic  en_b,
    input  logic  save_c,
    input  logic  en_add1,
    input  logic  en_add2,
    input  logic  en_f,
    input  data_t din,
    output data_t f
);

    data_t a_q, a_d;
    data_t b_q, b_d;
    data_t c_q, c_d;
    data_t acc1_q, acc1_d;
    data_t acc2_q, acc2_d;
    data_t f_q, f_d;

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        c_d    = c_q;
        acc1_d = acc1_q;
        acc2_d = acc2_q;
        f_d    = f_q;
        if (en_a)    a_d    = din;
        if (en_b)    b_d    = din;
        if (save_c)  c_d    = sat_mul(a_q, b_q);
        if (en_add1) acc1_d = sat_add(c_q, din);
        if (en_add2) acc2_d = sat_add(acc2_q, acc1_q);
        if (en_f)    f_d    = acc2_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            acc1_q <= '0;
            acc2_q <= '0;
            f_q    <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            c_q    <= c_d;
            acc1_q <= acc1_d;
            acc2_q <= acc2_d;
            f_q    <= f_d;
        end
    end

    assign f = f_q;

endmodule

// File: rtl/datapath.sv
// Four-lane saturating vector datapath: f_i accumulates sat(a_i*b_i)+din.
// din, save_c, clk and rst are shared; every other control is per lane.
module datapath
    import datapath_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en_a1,
    input  logic  en_a2,
    input  logic  en_a3,
    input  logic  en_a4,
    input  logic  en_b1,
    input  logic  en_b2,
    input  logic  en_b3,
    input  logic  en_b4,
    input  logic  save_c,
    input  logic  en_add1_1,
    input  logic  en_add1_2,
    input  logic  en_add1_3,
    input  logic  en_add1_4,
    input  logic  en_add2_1,
    input  logic  en_add2_2,
    input  logic  en_add2_3,
    input  logic  en_add2_4,
    input  logic  en_f1,
    input  logic  en_f2,
    input  logic  en_f3,
    input  logic  en_f4,
    input  data_t din,
    output data_t f1,
    output data_t f2,
    output data_t f3,
    output data_t f4
);

    logic [3:0] en_a, en_b, en_add1, en_add2, en_f;
    data_t      f_lane [4];

    assign en_a    = {en_a4, en_a3, en_a2, en_a1};
    assign en_b    = {en_b4, en_b3, en_b2, en_b1};
    assign en_add1 = {en_add1_4, en_add1_3, en_add1_2, en_add1_1};
    assign en_add2 = {en_add2_4, en_add2_3, en_add2_2, en_add2_1};
    assign en_f    = {en_f4, en_f3, en_f2, en_f1};

    for (genvar i = 0; i < 4; i++) begin : g_lane
        datapath_lane u_lane (
            .clk     (clk),
            .rst     (rst),
            .en_a    (en_a[i]),
            .en_b    (en_b[i]),
            .save_c  (save_c),
            .en_add1 (en_add1[i]),
            .en_add2 (en_add2[i]),
            .en_f    (en_f[i]),
            .din     (din),
            .f       (f_lane[i])
        );
    end

    assign f1 = f_lane[0];
    assign f2 = f_lane[1];
    assign f3 = f_lane[2];
    assign f4 = f_lane[3];

endmodule

// File: tb/tb_datapath.sv
// Bench for datapath: directed vector table for the lane scenarios, async
// reset sequence, then random stimulus against an integer lane model.
module tb_datapath;

    logic              clk;
    logic              rst;
    logic [3:0]        ea, eb, e1, e2, ef;
    logic              sc;
    logic signed [7:0] din;
    logic signed [7:0] f1, f2, f3, f4;

    int errors = 0;
    int checks = 0;

    // integer reference model of the four lanes
    int ma[4], mb[4], mc[4], m1[4], m2[4], mf[4];

    typedef struct packed {
        logic [3:0]       ea, eb, e1, e2, ef;
        logic             sc;
        logic [7:0]       d;
        logic [3:0][7:0]  exp_f;
    } vec_t;

    vec_t vecs[$];

    datapath dut (
        .clk(clk), .rst(rst),
        .en_a1(ea[0]), .en_a2(ea[1]), .en_a3(ea[2]), .en_a4(ea[3]),
        .en_b1(eb[0]), .en_b2(eb[1]), .en_b3(eb[2]), .en_b4(eb[3]),
        .save_c(sc),
        .en_add1_1(e1[0]), .en_add1_2(e1[1]), .en_add1_3(e1[2]), .en_add1_4(e1[3]),
        .en_add2_1(e2[0]), .en_add2_2(e2[1]), .en_add2_3(e2[2]), .en_add2_4(e2[3]),
        .en_f1(ef[0]), .en_f2(ef[1]), .en_f3(ef[2]), .en_f4(ef[3]),
        .din(din),
        .f1(f1), .f2(f2), .f3(f3), .f4(f4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int clamp(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic int f_act(input int i);
        case (i)
            0: return int'(f1);
            1: return int'(f2);
            2: return int'(f3);
            default: return int'(f4);
        endcase
    endfunction

    function automatic vec_t mk(input logic [3:0] a, b, s1, s2, sf, input logic s,
                                input int d, input int x1, x2, x3, x4);
        vec_t v;
        v.ea = a; v.eb = b; v.e1 = s1; v.e2 = s2; v.ef = sf; v.sc = s;
        v.d = 8'(d);
        v.exp_f[0] = 8'(x1); v.exp_f[1] = 8'(x2);
        v.exp_f[2] = 8'(x3); v.exp_f[3] = 8'(x4);
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            ma[i] = 0; mb[i] = 0; mc[i] = 0; m1[i] = 0; m2[i] = 0; mf[i] = 0;
        end
    endtask

    // One clock edge of the specification: all updates from pre-edge values.
    task automatic model_step();
        int d;
        d = int'(din);
        for (int i = 0; i < 4; i++) begin
            int na, nb, nc, n1, n2, nf;
            na = ea[i] ? d : ma[i];
            nb = eb[i] ? d : mb[i];
            nc = sc ? clamp(ma[i] * mb[i]) : mc[i];
            n1 = e1[i] ? clamp(mc[i] + d) : m1[i];
            n2 = e2[i] ? clamp(m2[i] + m1[i]) : m2[i];
            nf = ef[i] ? m2[i] : mf[i];
            ma[i] = na; mb[i] = nb; mc[i] = nc; m1[i] = n1; m2[i] = n2; mf[i] = nf;
        end
    endtask

    task automatic drive_idle();
        ea = '0; eb = '0; e1 = '0; e2 = '0; ef = '0; sc = 1'b0; din = '0;
    endtask

    // drive on falling edge, clock, then sample 2 time units after the edge
    task automatic apply(input vec_t v);
        @(negedge clk);
        ea = v.ea; eb = v.eb; e1 = v.e1; e2 = v.e2; ef = v.ef; sc = v.sc;
        din = v.d;
        @(posedge clk);
        model_step();
        #2;
    endtask

    initial begin
        drive_idle();
        model_reset();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) check($sformatf("por_f%0d", i + 1), f_act(i), 0);

        // enables are ignored while reset is held
        @(negedge clk);
        ea = '1; eb = '1; e1 = '1; e2 = '1; ef = '1; sc = 1'b1; din = 8'sd33;
        repeat (2) @(posedge clk);
        #2;
        for (int i = 0; i < 4; i++) check($sformatf("rst_hold_f%0d", i + 1), f_act(i), 0);
        @(negedge clk);
        drive_idle();
        rst = 1'b1;

        vecs.push_back(mk(4'h1, 0, 0, 0, 0, 0,  10,   0,    0,    0,    0));
        vecs.push_back(mk(4'h2, 0, 0, 0, 0, 0,  20,   0,    0,    0,    0));
        vecs.push_back(mk(4'h4, 0, 0, 0, 0, 0,  30,   0,    0,    0,    0));
        vecs.push_back(mk(4'h8, 0, 0, 0, 0, 0,  40,   0,    0,    0,    0));
        vecs.push_back(mk(0, 4'h1, 0, 0, 0, 0,  -5,   0,    0,    0,    0));
        vecs.push_back(mk(0, 4'h2, 0, 0, 0, 0, -15,   0,    0,    0,    0));
        vecs.push_back(mk(0, 4'h4, 0, 0, 0, 0, -25,   0,    0,    0,    0));
        vecs.push_back(mk(0, 4'h8, 0, 0, 0, 0, -35,   0,    0,    0,    0));
        vecs.push_back(mk(0, 4'h1, 0, 0, 0, 0,   3,   0,    0,    0,    0));
        vecs.push_back(mk(4'h1, 0, 0, 0, 0, 1,   3,   0,    0,    0,    0));
        vecs.push_back(mk(0, 0, 4'h1, 0, 0, 0,   7,   0,    0,    0,    0));
        vecs.push_back(mk(0, 0, 4'h2, 0, 0, 0,   8,   0,    0,    0,    0));
        vecs.push_back(mk(0, 0, 4'h4, 0, 0, 0,   9,   0,    0,    0,    0));
        vecs.push_back(mk(0, 0, 4'h8, 0, 0, 0,  10,   0,    0,    0,    0));
        vecs.push_back(mk(0, 0, 0, 4'hf, 0, 0,   0,   0,    0,    0,    0));
        vecs.push_back(mk(0, 0, 0, 0, 4'hf, 0,   0,  37, -120, -119, -118));
        vecs.push_back(mk(0, 0, 0, 4'h2, 0, 0,   0,  37, -120, -119, -118));
        vecs.push_back(mk(0, 0, 0, 0, 4'h2, 0,   0,  37, -128, -119, -118));
        vecs.push_back(mk(4'h1, 0, 0, 0, 0, 0, 127,  37, -128, -119, -118));
        vecs.push_back(mk(0, 4'h1, 0, 0, 0, 0, 127,  37, -128, -119, -118));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,      0,  37, -128, -119, -118));
        vecs.push_back(mk(0, 0, 4'h1, 0, 0, 0,   1,  37, -128, -119, -118));
        vecs.push_back(mk(0, 0, 0, 4'h1, 0, 0,   0,  37, -128, -119, -118));
        vecs.push_back(mk(0, 0, 0, 0, 4'h1, 0,   0, 127, -128, -119, -118));
        vecs.push_back(mk(4'h4, 4'h4, 0, 0, 0, 0, 55, 127, -128, -119, -118));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,      0, 127, -128, -119, -118));
        vecs.push_back(mk(0, 0, 4'h4, 0, 0, 0,   0, 127, -128, -119, -118));
        vecs.push_back(mk(0, 0, 0, 4'h4, 0, 0,   0, 127, -128, -119, -118));
        vecs.push_back(mk(0, 0, 0, 4'h4, 4'h4, 0, 0, 127, -128,   8, -118));
        vecs.push_back(mk(0, 0, 0, 0, 4'h4, 0,   0, 127, -128,  127, -118));
        vecs.push_back(mk(0, 0, 4'h8, 4'h8, 0, 0, 12, 127, -128, 127, -118));
        vecs.push_back(mk(0, 0, 0, 0, 4'h8, 0,   0, 127, -128,  127, -128));

        for (int k = 0; k < vecs.size(); k++) begin
            apply(vecs[k]);
            for (int i = 0; i < 4; i++)
                check($sformatf("vec%0d_f%0d", k, i + 1), f_act(i), int'($signed(vecs[k].exp_f[i])));
        end

        // async reset between edges with non-zero state
        @(negedge clk);
        drive_idle();
        #2 rst = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 4; i++) check($sformatf("async_rst_f%0d", i + 1), f_act(i), 0);
        @(negedge clk);
        ea = '1; eb = '1; e1 = '1; e2 = '1; ef = '1; sc = 1'b1; din = 8'sd50;
        repeat (3) begin
            @(posedge clk);
            #2;
            for (int i = 0; i < 4; i++) check($sformatf("rst_low_f%0d", i + 1), f_act(i), 0);
        end
        @(negedge clk);
        drive_idle();
        rst = 1'b1;

        // internal registers cleared: f sees zero acc2, then c+din with c=0
        apply(mk(0, 0, 0, 0, 4'hf, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) check($sformatf("post_rst_f%0d", i + 1), f_act(i), 0);
        apply(mk(0, 0, 4'hf, 0, 0, 0, 5, 0, 0, 0, 0));
        apply(mk(0, 0, 0, 4'hf, 0, 0, 0, 0, 0, 0, 0));
        apply(mk(0, 0, 0, 0, 4'hf, 0, 0, 5, 5, 5, 5));
        for (int i = 0; i < 4; i++) check($sformatf("post_rst_acc_f%0d", i + 1), f_act(i), 5);

        // random stimulus against the model
        for (int n = 0; n < 400; n++) begin
            vec_t v;
            v = '0;
            for (int i = 0; i < 4; i++) begin
                v.ea[i] = ($urandom_range(0, 3) == 0);
                v.eb[i] = ($urandom_range(0, 3) == 0);
                v.e1[i] = ($urandom_range(0, 2) == 0);
                v.e2[i] = ($urandom_range(0, 2) == 0);
                v.ef[i] = ($urandom_range(0, 2) == 0);
            end
            v.sc = ($urandom_range(0, 3) == 0);
            v.d  = 8'($urandom_range(0, 255));
            apply(v);
            for (int i = 0; i < 4; i++)
                check($sformatf("rand%0d_f%0d", n, i + 1), f_act(i), mf[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/datapath.md
Name: datapath

Overview:
- Four-lane, 8-bit signed vector datapath for the application-specific vector processor.
- Each lane i (1..4) holds operand registers a_i and b_i, a product register c_i, two accumulators acc1_i and acc2_i, and an output register f_i.
- The external controller drives per-lane enables and a shared data bus din; the block computes f_i = Σ(sat(a_i·b_i) + din) per lane with saturation.
- Sits between the controller FSM and the result bus.

Parameters:
- DATA_W, 8, width of din, all internal registers and f outputs. Ports are fixed at 8; the parameter exists for package consistency only.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- en_a1..en_a4  input  1 each  load din into a_i
- en_b1..en_b4  input  1 each  load din into b_i
- save_c  input  1  capture saturated products of all four lanes into c_1..c_4
- en_add1_1..en_add1_4  input  1 each  acc1_i <= sat(c_i + din)
- en_add2_1..en_add2_4  input  1 each  acc2_i <= sat(acc2_i + acc1_i)
- en_f1..en_f4  input  1 each  f_i <= acc2_i
- din  input  8  signed two's-complement data bus
- f1..f4  output  8 each  signed registered lane results

Behaviour:
- Reset:
  - Asynchronous, active-low: rst=0 immediately clears a, b, c, acc1, acc2 and f in all lanes to 0.
  - Registers hold 0 while rst=0; normal operation resumes on the first rising clk edge with rst=1.
- Register updates: all updates occur on the rising clk edge. Every register holds its value when its enable is 0.
- Latency:
  - One cycle from enable to register update.
  - f_i changes on the edge where en_f_i=1.
  - No combinational path from any input to f.
- Same-edge rule: all right-hand sides use pre-edge register values.
  - save_c together with en_a_i/en_b_i: the product uses the old a_i/b_i.
  - en_add1_i together with en_add2_i: acc2_i adds the old acc1_i.
  - en_add2_i together with en_f_i: f_i takes the old acc2_i.
- Enable independence: any combination may be asserted together. en_a_i and en_b_i together load din into both registers.
- Multiply: c_i <= sat8(a_i × b_i). The full 16-bit signed product is clamped to [-128, 127]. save_c is shared by all four lanes.
- Adders: 9-bit signed sum, clamped to [-128, 127]. No wrap-around.
- There is no handshake, no state machine and no X-propagation. Unused lanes simply hold their values.

Decomposition:
- Shared package holds:
  - DATA_W
  - the signed data typedef (8-bit)
  - the saturation limits SAT_MAX=127 and SAT_MIN=-128
  - saturation helper functions sat_add and sat_mul
- Natural sub-module: datapath_lane. It holds one lane's a, b, c, acc1, acc2 and f registers, the multiplier and the two adders, and is instantiated four times.
- The top level fans din, save_c, clk and rst out to the lanes and maps the per-lane enables.

Test Plan:
- Operand load: release rst. Load a1..a4 with 10, 20, 30, 40 and b1..b4 with -5, -15, -25, -35, one enable per cycle.
  - Expect each register to update only on the edge of its enable.
  - Expect f1..f4 to remain 0.
- Multiply with saturation: load b1=3, then assert save_c with en_a1=1 and din=3 in the same cycle.
  - Expect c = 30, -128, -128, -128 (raw products 30, -300, -750, -1400).
  - Expect a1 = 3 afterwards.
- Add chain: assert en_add1_i with din = 7, 8, 9, 10, then en_add2_1..4, then en_f1..4.
  - Expect acc1 = 37, -120, -119, -118.
  - Expect f1..f4 = 37, -120, -119, -118.
- Saturating accumulate: repeat en_add2_2 once more.
  - Expect acc2_2 = sat(-120 + -120) = -128.
  - Then en_f2 gives f2 = -128.
  - Positive case: a1=127, b1=127, save_c -> c1=127; en_add1_1 with din=1 -> acc1_1=127 (saturated).
- Simultaneous events:
  - din=55 with en_a3 and en_b3 -> a3 = b3 = 55.
  - Then din=12 with en_add1_4 and en_add2_4 -> acc1_4 = sat(-128 + 12) = -116, and acc2_4 = sat(-118 + -118) = -128 (uses old acc1_4).
- Async reset mid-operation: pull rst low between clock edges with non-zero state.
  - Expect f1..f4 and all internal registers = 0 immediately, before the next edge.
  - Expect them to stay 0 while rst=0, with enables ignored.
